// File: rtl/quad_encoder_emulator.sv
// Quadrature A/B and pushbutton stimulus generator, driven by independent
// valid/ready step and press channels, with a wrapping 4-bit detent position.
//
// state  | meaning
// S_IDLE | step channel ready, A/B resting at 11
// S_PH1  | accepted; first transition issued, then first phase held
// S_PH2  | second quadrature phase held
// S_PH3  | third quadrature phase held
// S_PH4  | back at 11, holding the final phase before returning idle
// P_IDLE | press channel ready, PB high
// P_LOW1 | first (or only) low pulse
// P_GAP  | high gap between the two pulses of a double press
// P_LOW2 | second low pulse of a double press
// P_REL  | released, PB held high before accepting a new press
module quad_encoder_emulator #(
  parameter int PHASE_CYCLES = 1000,
  parameter int SHORT_CYCLES = 5000,
  parameter int LONG_CYCLES  = 50000,
  parameter int GAP_CYCLES   = 5000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       step_valid,
  input  logic       step_dir,
  output logic       step_ready,
  input  logic       pb_valid,
  input  logic [1:0] pb_type,
  output logic       pb_ready,
  output logic       A,
  output logic       B,
  output logic       PB,
  output logic [3:0] position,
  output logic       busy
);

  localparam int PB_MAX = (LONG_CYCLES > SHORT_CYCLES)
                        ? ((LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES)
                        : ((SHORT_CYCLES > GAP_CYCLES) ? SHORT_CYCLES : GAP_CYCLES);
  localparam int SW = $clog2(PHASE_CYCLES) + 1;
  localparam int PW = $clog2(PB_MAX) + 1;

  localparam logic [SW-1:0] PH_FULL  = SW'(PHASE_CYCLES);
  localparam logic [SW-1:0] PH_LD    = SW'(PHASE_CYCLES - 1);
  localparam logic [PW-1:0] SHORT_LD = PW'(SHORT_CYCLES - 1);
  localparam logic [PW-1:0] LONG_LD  = PW'(LONG_CYCLES - 1);
  localparam logic [PW-1:0] GAP_LD   = PW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] REL_LD   = PW'(GAP_CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_PH1, S_PH2, S_PH3, S_PH4} step_state_e;
  typedef enum logic [2:0] {P_IDLE, P_LOW1, P_GAP, P_LOW2, P_REL} pb_state_e;

  step_state_e   step_state_q, step_state_d;
  logic [SW-1:0] step_cnt_q, step_cnt_d;
  logic          dir_q, dir_d;
  logic          a_q, a_d, b_q, b_d;
  logic [3:0]    pos_q, pos_d;
  logic          odd_edge, even_edge;

  pb_state_e     pb_state_q, pb_state_d;
  logic [PW-1:0] pb_cnt_q, pb_cnt_d;
  logic [1:0]    type_q, type_d;
  logic          pb_q, pb_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      step_state_q <= S_IDLE;
      step_cnt_q   <= '0;
      dir_q        <= 1'b0;
      a_q          <= 1'b1;
      b_q          <= 1'b1;
      pos_q        <= 4'd0;
      pb_state_q   <= P_IDLE;
      pb_cnt_q     <= '0;
      type_q       <= 2'b00;
      pb_q         <= 1'b1;
    end else begin
      step_state_q <= step_state_d;
      step_cnt_q   <= step_cnt_d;
      dir_q        <= dir_d;
      a_q          <= a_d;
      b_q          <= b_d;
      pos_q        <= pos_d;
      pb_state_q   <= pb_state_d;
      pb_cnt_q     <= pb_cnt_d;
      type_q       <= type_d;
      pb_q         <= pb_d;
    end
  end

  // S_PH1 starts one count above a full phase so the first transition lands
  // one edge after accept; later transitions fire as each phase expires.
  always_comb begin
    step_state_d = step_state_q;
    step_cnt_d   = step_cnt_q;
    dir_d        = dir_q;
    odd_edge     = 1'b0;
    even_edge    = 1'b0;
    case (step_state_q)
      S_IDLE: if (step_valid) begin
        step_state_d = S_PH1;
        step_cnt_d   = PH_FULL;
        dir_d        = step_dir;
      end
      S_PH1: if (step_cnt_q == PH_FULL) begin
        odd_edge   = 1'b1;
        step_cnt_d = step_cnt_q - 1'b1;
      end else if (step_cnt_q == '0) begin
        even_edge    = 1'b1;
        step_state_d = S_PH2;
        step_cnt_d   = PH_LD;
      end else begin
        step_cnt_d = step_cnt_q - 1'b1;
      end
      S_PH2: if (step_cnt_q == '0) begin
        odd_edge     = 1'b1;
        step_state_d = S_PH3;
        step_cnt_d   = PH_LD;
      end else begin
        step_cnt_d = step_cnt_q - 1'b1;
      end
      S_PH3: if (step_cnt_q == '0) begin
        even_edge    = 1'b1;
        step_state_d = S_PH4;
        step_cnt_d   = PH_LD;
      end else begin
        step_cnt_d = step_cnt_q - 1'b1;
      end
      S_PH4: if (step_cnt_q == '0) begin
        step_state_d = S_IDLE;
      end else begin
        step_cnt_d = step_cnt_q - 1'b1;
      end
      default: step_state_d = S_IDLE;
    endcase
  end

  // CW toggles A on odd transitions and B on even ones; CCW is the mirror.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    pos_d = pos_q;
    if (odd_edge) begin
      if (dir_q) a_d = ~a_q;
      else       b_d = ~b_q;
    end
    if (even_edge) begin
      if (dir_q) b_d = ~b_q;
      else       a_d = ~a_q;
    end
    if (even_edge && step_state_q == S_PH3)
      pos_d = dir_q ? pos_q + 4'd1 : pos_q - 4'd1;
  end

  // PB is registered from the current state, so it trails the FSM by one
  // edge; REL loads a full GAP count to keep ready aligned with PB.
  always_comb begin
    pb_state_d = pb_state_q;
    pb_cnt_d   = pb_cnt_q;
    type_d     = type_q;
    pb_d       = !(pb_state_q == P_LOW1 || pb_state_q == P_LOW2);
    case (pb_state_q)
      P_IDLE: if (pb_valid) begin
        pb_state_d = P_LOW1;
        type_d     = pb_type;
        pb_cnt_d   = (pb_type == 2'b01) ? LONG_LD : SHORT_LD;
      end
      P_LOW1: if (pb_cnt_q == '0) begin
        if (type_q == 2'b10) begin
          pb_state_d = P_GAP;
          pb_cnt_d   = GAP_LD;
        end else begin
          pb_state_d = P_REL;
          pb_cnt_d   = REL_LD;
        end
      end else begin
        pb_cnt_d = pb_cnt_q - 1'b1;
      end
      P_GAP: if (pb_cnt_q == '0) begin
        pb_state_d = P_LOW2;
        pb_cnt_d   = SHORT_LD;
      end else begin
        pb_cnt_d = pb_cnt_q - 1'b1;
      end
      P_LOW2: if (pb_cnt_q == '0) begin
        pb_state_d = P_REL;
        pb_cnt_d   = REL_LD;
      end else begin
        pb_cnt_d = pb_cnt_q - 1'b1;
      end
      P_REL: if (pb_cnt_q == '0) begin
        pb_state_d = P_IDLE;
      end else begin
        pb_cnt_d = pb_cnt_q - 1'b1;
      end
      default: pb_state_d = P_IDLE;
    endcase
  end

  assign A          = a_q;
  assign B          = b_q;
  assign PB         = pb_q;
  assign position   = pos_q;
  assign step_ready = (step_state_q == S_IDLE);
  assign pb_ready   = (pb_state_q == P_IDLE);
  assign busy       = !step_ready || !pb_ready;

endmodule

// File: tb/tb_quad_encoder_emulator.sv
// Self-checking bench: directed and random commands compared cycle by cycle
// against timing windows derived from the encoder's published waveforms.
module tb_quad_encoder_emulator;

  localparam int P = 4;
  localparam int S = 3;
  localparam int L = 10;
  localparam int G = 2;

  logic       clk = 1'b0;
  logic       rstn;
  logic       step_valid, step_dir, pb_valid;
  logic [1:0] pb_type;
  logic       step_ready, pb_ready, A, B, PB, busy;
  logic [3:0] position;

  logic       f_step_valid, f_step_dir, f_pb_valid;
  logic [1:0] f_pb_type;
  logic       f_step_ready, f_pb_ready, f_A, f_B, f_PB, f_busy;
  logic [3:0] f_position;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] pos_model;
  logic [3:0] fpos_model;
  logic [1:0] prev_ab;
  int         dec_q;
  logic [1:0] eab_f;
  bit         fdir;

  always #5 clk = ~clk;

  quad_encoder_emulator #(
    .PHASE_CYCLES(P), .SHORT_CYCLES(S), .LONG_CYCLES(L), .GAP_CYCLES(G)
  ) u_dut (
    .clk(clk), .rstn(rstn),
    .step_valid(step_valid), .step_dir(step_dir), .step_ready(step_ready),
    .pb_valid(pb_valid), .pb_type(pb_type), .pb_ready(pb_ready),
    .A(A), .B(B), .PB(PB), .position(position), .busy(busy)
  );

  quad_encoder_emulator #(
    .PHASE_CYCLES(1), .SHORT_CYCLES(1), .LONG_CYCLES(1), .GAP_CYCLES(1)
  ) u_fast (
    .clk(clk), .rstn(rstn),
    .step_valid(f_step_valid), .step_dir(f_step_dir), .step_ready(f_step_ready),
    .pb_valid(f_pb_valid), .pb_type(f_pb_type), .pb_ready(f_pb_ready),
    .A(f_A), .B(f_B), .PB(f_PB), .position(f_position), .busy(f_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // A/B after t edges past accept: each phase of the detent is held p cycles.
  function automatic logic [1:0] exp_ab(input bit active, input bit dir, input int t, input int p);
    int idx;
    if (!active || t < 1) return 2'b11;
    idx = (t - 1) / p;
    case (idx)
      0:       return dir ? 2'b01 : 2'b10;
      1:       return 2'b00;
      2:       return dir ? 2'b10 : 2'b01;
      default: return 2'b11;
    endcase
  endfunction

  function automatic int pb_len(input logic [1:0] typ);
    if (typ == 2'b01) return L + G + 1;
    if (typ == 2'b10) return 2*S + 2*G + 1;
    return S + G + 1;
  endfunction

  function automatic bit pb_low(input logic [1:0] typ, input int t);
    int first;
    first = (typ == 2'b01) ? L : S;
    if (t >= 1 && t <= first) return 1'b1;
    if (typ == 2'b10 && t >= S + G + 1 && t <= 2*S + G) return 1'b1;
    return 1'b0;
  endfunction

  // Quarter index along the CW cycle 11 -> 01 -> 00 -> 10.
  function automatic int qidx(input logic [1:0] ab);
    case (ab)
      2'b11:   return 0;
      2'b01:   return 1;
      2'b00:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic chk_cycle(input int t, input bit ds, input bit dir, input bit dp, input logic [1:0] typ);
    logic [1:0] eab;
    logic [3:0] epos;
    logic       esr, epr;
    int         d;
    eab  = exp_ab(ds, dir, t, P);
    epos = pos_model;
    if (ds && t >= 3*P + 1) epos = dir ? pos_model + 4'd1 : pos_model - 4'd1;
    esr = !ds || (t >= 4*P + 1);
    epr = !dp || (t >= pb_len(typ));
    chk("A", A, eab[1]);
    chk("B", B, eab[0]);
    chk("PB", PB, !(dp && pb_low(typ, t)));
    chk("step_ready", step_ready, esr);
    chk("pb_ready", pb_ready, epr);
    chk("busy", busy, !(esr && epr));
    chk("position", position, epos);
    d = (qidx({A, B}) - qidx(prev_ab) + 4) % 4;
    chk("gray_step", (d == 2), 1'b0);
    if (d == 1) dec_q++;
    if (d == 3) dec_q--;
    prev_ab = {A, B};
  endtask

  task automatic run_cmd(input bit ds, input bit dir, input bit dp, input logic [1:0] typ);
    int slen, plen, tmax;
    slen = ds ? 4*P + 1 : 0;
    plen = dp ? pb_len(typ) : 0;
    tmax = (slen > plen) ? slen : plen;
    @(negedge clk);
    step_valid = ds; step_dir = dir; pb_valid = dp; pb_type = typ;
    @(posedge clk); #1;
    for (int t = 0; t <= tmax; t++) begin
      if (t >= 1 && t <= 3) begin
        step_valid = ds & 1'($urandom_range(0, 1));
        pb_valid   = dp & 1'($urandom_range(0, 1));
        step_dir   = 1'($urandom_range(0, 1));
        pb_type    = 2'($urandom_range(0, 3));
      end else begin
        step_valid = 1'b0;
        pb_valid   = 1'b0;
      end
      chk_cycle(t, ds, dir, dp, typ);
      if (t < tmax) begin
        @(posedge clk); #1;
      end
    end
    if (ds) pos_model = dir ? pos_model + 4'd1 : pos_model - 4'd1;
  endtask

  task automatic chk_reset_values();
    chk("rst_A", A, 1'b1);
    chk("rst_B", B, 1'b1);
    chk("rst_PB", PB, 1'b1);
    chk("rst_step_ready", step_ready, 1'b1);
    chk("rst_pb_ready", pb_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_position", position, 4'd0);
    chk("rst_fast_position", f_position, 4'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ds, dp;
    rstn = 1'b0;
    step_valid = 1'b0; step_dir = 1'b0; pb_valid = 1'b0; pb_type = 2'b00;
    f_step_valid = 1'b0; f_step_dir = 1'b0; f_pb_valid = 1'b0; f_pb_type = 2'b00;
    pos_model = 4'd0; fpos_model = 4'd0; prev_ab = 2'b11; dec_q = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_values();
    @(negedge clk);
    rstn = 1'b1;

    // Abort mid-command: step in the second phase, press still in its first low.
    @(negedge clk);
    step_valid = 1'b1; step_dir = 1'b1; pb_valid = 1'b1; pb_type = 2'b01;
    @(posedge clk); #1;
    step_valid = 1'b0; pb_valid = 1'b0;
    for (int t = 0; t <= P + 2; t++) begin
      chk_cycle(t, 1'b1, 1'b1, 1'b1, 2'b01);
      if (t < P + 2) begin
        @(posedge clk); #1;
      end
    end
    #1 rstn = 1'b0;
    #1;
    chk_reset_values();
    prev_ab = {A, B};
    @(posedge clk); #1;
    rstn = 1'b1;

    // First command after release is accepted immediately; loopback 5 CW, 2 CCW.
    dec_q = 0;
    for (int i = 0; i < 5; i++) run_cmd(1'b1, 1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 2; i++) run_cmd(1'b1, 1'b0, 1'b0, 2'b00);
    chk("loopback_decoder", dec_q / 4, 3);
    chk("loopback_position", position, 4'd3);

    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk_reset_values();
    pos_model = 4'd0;
    prev_ab = {A, B};
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 17; i++) begin
      run_cmd(1'b1, 1'b0, 1'b0, 2'b00);
      if (i == 0)  chk("ccw_wrap_first", position, 4'd15);
      if (i == 16) chk("ccw_wrap_17th", position, 4'd15);
    end

    run_cmd(1'b1, 1'b1, 1'b1, 2'b00);
    run_cmd(1'b0, 1'b0, 1'b1, 2'b01);
    run_cmd(1'b0, 1'b0, 1'b1, 2'b10);
    run_cmd(1'b0, 1'b0, 1'b1, 2'b11);
    run_cmd(1'b1, 1'b0, 1'b1, 2'b10);

    for (int i = 0; i < 20; i++) begin
      ds = 1'($urandom_range(0, 1));
      dp = 1'($urandom_range(0, 1));
      if (!ds && !dp) ds = 1'b1;
      run_cmd(ds, 1'($urandom_range(0, 1)), dp, 2'($urandom_range(0, 3)));
    end

    // One-cycle phases: every quadrature state appears for exactly one cycle.
    for (int s = 0; s < 2; s++) begin
      fdir = (s == 0);
      @(negedge clk);
      f_step_valid = 1'b1; f_step_dir = fdir;
      @(posedge clk); #1;
      f_step_valid = 1'b0; f_step_dir = ~fdir;
      for (int t = 0; t <= 5; t++) begin
        eab_f = exp_ab(1'b1, fdir, t, 1);
        chk("fast_A", f_A, eab_f[1]);
        chk("fast_B", f_B, eab_f[0]);
        chk("fast_step_ready", f_step_ready, (t >= 5));
        chk("fast_busy", f_busy, (t < 5));
        chk("fast_PB", f_PB, 1'b1);
        chk("fast_pb_ready", f_pb_ready, 1'b1);
        chk("fast_position", f_position,
            (t >= 4) ? (fdir ? fpos_model + 4'd1 : fpos_model - 4'd1) : fpos_model);
        if (t < 5) begin
          @(posedge clk); #1;
        end
      end
      fpos_model = fdir ? fpos_model + 4'd1 : fpos_model - 4'd1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
